// File: rtl/port_responder.sv
// port_responder: memory-side responder for the toggle-handshake ROM/data port.
// A flip of port_req starts one access on the ready/valid memory bus; the access
// completes by flipping port_ack (reads also update port_q). Every memory phase
// is bounded by TIMEOUT cycles.
module port_responder #(
  parameter int AW      = 23,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          port_req,
  output logic          port_ack,
  input  logic [AW-1:0] port_a,
  input  logic [1:0]    port_ds,
  input  logic          port_we,
  input  logic [15:0]   port_d,
  output logic [15:0]   port_q,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [1:0]    mem_be,
  output logic [15:0]   mem_wdata,
  input  logic          mem_rdy,
  input  logic          mem_rvalid,
  input  logic [15:0]   mem_rdata,
  output logic          busy,
  output logic          err_timeout,
  input  logic          err_clear
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RDWAIT, S_ACK} state_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  state_t        state_q, state_d;
  logic          ack_q, ack_d;
  logic [15:0]   q_q, q_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [1:0]    be_q, be_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   rbuf_q, rbuf_d;
  logic [1:0]    lds_q, lds_d;
  logic          lwe_q, lwe_d;
  logic          tout_q, tout_d;
  logic          busy_q;
  logic [15:0]   cnt_inc;

  // Next-state and datapath: capture, command, read wait, acknowledge.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    q_d     = q_q;
    req_d   = req_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rbuf_d  = rbuf_q;
    lds_d   = lds_q;
    lwe_d   = lwe_q;
    tout_d  = tout_q;
    cnt_inc = cnt_q + 16'd1;

    // Clear first so a coincident timeout below overrides it.
    if (err_clear) err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (port_req != ack_q) begin
          lds_d  = port_ds;
          lwe_d  = port_we;
          tout_d = 1'b0;
          if (port_ds == 2'b00) begin
            state_d = S_ACK;
          end else begin
            addr_d  = port_a;
            we_d    = port_we;
            be_d    = port_ds;
            wdata_d = port_d;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_CMD;
          end
        end
      end
      S_CMD: begin
        cnt_d = cnt_inc;
        if (mem_rdy) begin
          req_d   = 1'b0;
          state_d = lwe_q ? S_ACK : S_RDWAIT;
        end else if (cnt_inc == TO_LIMIT) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          tout_d  = 1'b1;
          state_d = S_ACK;
        end
      end
      S_RDWAIT: begin
        cnt_d = cnt_inc;
        if (mem_rvalid) begin
          rbuf_d  = mem_rdata;
          state_d = S_ACK;
        end else if (cnt_inc == TO_LIMIT) begin
          err_d   = 1'b1;
          tout_d  = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        ack_d = ~ack_q;
        if (!lwe_q && !tout_q) begin
          if (lds_q[1]) q_d[15:8] = rbuf_q[15:8];
          if (lds_q[0]) q_d[7:0]  = rbuf_q[7:0];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      q_q     <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rbuf_q  <= '0;
      lds_q   <= '0;
      lwe_q   <= 1'b0;
      tout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
      lds_q   <= lds_d;
      lwe_q   <= lwe_d;
      tout_q  <= tout_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign port_ack    = ack_q;
  assign port_q      = q_q;
  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign mem_we      = we_q;
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: doc/port_responder.md
# port_responder

Memory-side responder for the toggle-handshake ROM/data port used between the ROM download controller and the memory subsystem. A requester signals a new access by flipping `port_req`. This block latches the access and performs it on a simple ready/valid memory bus. It then completes the access by flipping `port_ack`, and for reads it also returns data on `port_q`. It sits between the download/loader logic and a BRAM or SRAM-style backing store, and bounds every access with a timeout.

## Interface
Parameters:
- `AW`, default 23: word address width.
- `TIMEOUT`, default 255: maximum cycles in the memory phase before forced completion. Valid range is 1..65535.

Ports:
- `clk_sys`, in, 1: sole clock; all logic is on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `port_req`, in, 1: toggle request. An access is pending whenever `port_req != port_ack`.
- `port_ack`, out, 1: toggle acknowledge.
- `port_a`, in, AW: word address.
- `port_ds`, in, 2: byte selects. Bit 1 selects [15:8] and bit 0 selects [7:0].
- `port_we`, in, 1: 1 for write, 0 for read.
- `port_d`, in, 16: write data.
- `port_q`, out, 16: read data, held between accesses.
- `mem_req`, out, 1: memory command valid.
- `mem_addr`, out, AW: memory address.
- `mem_we`, out, 1: memory write.
- `mem_be`, out, 2: memory byte enables.
- `mem_wdata`, out, 16: memory write data.
- `mem_rdy`, in, 1: the command is accepted on any edge where `mem_req & mem_rdy`.
- `mem_rvalid`, in, 1: read data valid.
- `mem_rdata`, in, 16: read data.
- `busy`, out, 1: high in every state except IDLE.
- `err_timeout`, out, 1: sticky flag, set when an access times out.
- `err_clear`, in, 1: synchronous clear of `err_timeout`.

## Operation
- Reset values: `port_ack`=0, `port_q`=0, `mem_req`=0, `mem_addr`=0, `mem_we`=0, `mem_be`=0, `mem_wdata`=0, `busy`=0, `err_timeout`=0. The state goes to IDLE and the timeout counter to 0.
- Requester rule: `port_a`, `port_ds`, `port_we` and `port_d` are stable on the edge where the request is captured. Only one access is outstanding at a time.
- IDLE:
  - If an access is pending, latch `port_a`, `port_ds`, `port_we` and `port_d`.
  - If `port_ds`==00, go to ACK with no memory access.
  - Otherwise drive the `mem_*` command registers, set `mem_req`=1 and go to CMD.
- CMD: hold `mem_req` and the command.
  - On `mem_rdy`=1, set `mem_req`=0.
  - A write goes to ACK; a read goes to RDWAIT.
- RDWAIT: on `mem_rvalid`=1, latch `mem_rdata` into the read buffer and go to ACK. `mem_rvalid` is ignored in every other state.
- ACK:
  - Toggle `port_ack`.
  - For a non-timed-out read, update `port_q`: each byte lane whose `ds` bit is 1 takes the buffer byte, and lanes whose bit is 0 keep their previous `port_q` value.
  - Return to IDLE.
- Timeout:
  - The counter clears on entry to CMD and increments each cycle in CMD or RDWAIT.
  - When it reaches `TIMEOUT`, set `mem_req`=0 and `err_timeout`=1, and go to ACK. `port_q` is not updated in this case.
  - If the counter reaches `TIMEOUT` on the same edge that `mem_rdy` or `mem_rvalid` arrives, the normal completion wins and no error is flagged.
- If `err_clear` and a timeout coincide on the same edge, the set wins.
- A pending access is not re-detected until ACK has toggled `port_ack`. Back-to-back requests are therefore served one at a time with no loss.
- Asserting reset mid-access aborts it: outputs return to their reset values and `port_ack`=0. If `port_req`=1 after reset, a new pending access is detected and serviced using the current port inputs.
- The address passes through unchanged. There is no wrap or increment logic.

## Timing
- Call the edge on which IDLE captures a pending request edge E.
- `mem_req` is high from after E. With `mem_rdy`=1 throughout, the command is accepted at E+1.
- Write: ACK runs at E+2, so `port_ack` toggles at E+2 (3 edges including the capture). Throughput is one write per 4 cycles when the requester re-toggles immediately.
- Read with `mem_rvalid` at E+2: `port_ack` and `port_q` both change at E+3.
- Each cycle `mem_rdy` is held low adds one cycle of latency, up to `TIMEOUT`.
- An access with `ds`=00 completes at E+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then toggle `port_req` to 1 with a write to `a`=0x1234, `ds`=11, `d`=0xBEEF and `mem_rdy`=1. Required: one `mem_req` pulse with addr 0x1234, we=1, be=11, wdata 0xBEEF, and `port_ack`=1 exactly at E+2.
- Read from `a`=0x10 with `ds`=01 and previous `port_q`=0xAA55, memory returning 0x1234 one cycle after accept. Required: `port_q`=0xAA34, and `port_ack` toggles at E+3 on the same edge as the `port_q` update.
- Hold `mem_rdy` low for 7 cycles on a write. Required: `mem_req` and the command stay stable for 8 cycles and `port_ack` toggles 1 cycle after acceptance.
- Set `TIMEOUT`=16 and never assert `mem_rdy`. Required: `mem_req` drops, `err_timeout`=1, `port_ack` toggles, and `port_q` is unchanged; `err_clear` then returns the flag to 0.
- Issue 3 back-to-back writes, with the requester re-toggling on each ack. Required: exactly 3 memory commands in order and 3 ack toggles.
- Assert `reset_n` low while in RDWAIT with `port_req`=1. Required: all outputs go to reset values; after release the access is re-issued and acked, with `port_ack`=1.
